alu_datapath: RTL and testbench



---
 rtl/alu_datapath.sv | 184 ++++++++++++++++++
 tb/tb_alu_datapath.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_datapath.sv
// alu_datapath: operand/result datapath of the ALU.
// Holds the M, Q and A registers, the Booth extension bit q_m1, a step
// counter and a "sequence in progress" flag, and performs the register
// transfers requested by the decoded control word c0..c10.
//
// Optional feature: define ALU_DP_OVF_EN to build the signed overflow
// detector for M op Q. Without it ovf is tied low.
module alu_datapath #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] inbus,
    input  logic         c0,
    input  logic         c1,
    input  logic         c2,
    input  logic         c3,
    input  logic         c4,
    input  logic         c5,
    input  logic         c6,
    input  logic         c7,
    input  logic         c8,
    input  logic         c9,
    input  logic         c10,
    output logic [W-1:0] outbus,
    output logic         q0,
    output logic         q_m1,
    output logic         a_sign,
    output logic         cnt_zero,
    output logic         ovf
);

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [W-1:0]     m_q,   m_d;
    logic [W-1:0]     q_q,   q_d;
    logic [W-1:0]     a_q,   a_d;
    logic             qm1_q, qm1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seq_q, seq_d;

    // ------------------------------------------------------------------
    // Combinational arithmetic unit: M op Q, one extra bit for carry.
    // Subtract is M + ~Q + 1, so the top bit is the inverted borrow.
    // ------------------------------------------------------------------
    logic [W-1:0] q_opnd;
    logic [W:0]   sum;
    logic         carry_borrow;

    assign q_opnd = c3 ? ~q_q : q_q;
    assign sum    = {1'b0, m_q} + {1'b0, q_opnd} + {{W{1'b0}}, c3};

    // Borrow is M < Q unsigned, which is exactly the missing carry-out.
    assign carry_borrow = c3 ? ~sum[W] : sum[W];

    // ------------------------------------------------------------------
    // Result mux: before any sequence step the unit result is visible,
    // once a sequence has run the A/Q pair is returned instead.
    // ------------------------------------------------------------------
    logic [W-1:0] result1;
    logic [W-1:0] result0;

    assign result1 = seq_q ? a_q : {{(W-1){1'b0}}, carry_borrow};
    assign result0 = seq_q ? q_q : sum[W-1:0];

    // Output select: c7 has priority, idle bus reads zero.
    always_comb begin
        outbus = '0;
        if (c7)
            outbus = result1;
        else if (c8)
            outbus = result0;
    end

    // ------------------------------------------------------------------
    // Status outputs (all from post-edge registered state)
    // ------------------------------------------------------------------
    assign q0       = q_q[0];
    assign q_m1     = qm1_q;
    assign a_sign   = a_q[W-1];
    assign cnt_zero = (cnt_q == '0);

`ifdef ALU_DP_OVF_EN
    // Operand signs (after the subtract inversion) agree but the result
    // sign differs; meaningless while A/Q are being sequenced.
    assign ovf = ~seq_q
               & (m_q[W-1] == q_opnd[W-1])
               & (sum[W-1] != m_q[W-1]);
`else
    assign ovf = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state for A, Q, q_m1. Within one cycle the ordering is:
    // left shift, then A op M, then right shift, then Q[0] force.
    // This gives a full Booth step (c2+c4) or a non-restoring division
    // step (c5+c2, optionally +c6) per clock. c1 overrides everything.
    // ------------------------------------------------------------------
    logic [W-1:0] a_t;
    logic [W-1:0] q_t;
    logic         qm1_t;
    logic [W-1:0] m_opnd;

    assign m_opnd = c3 ? ~m_q : m_q;

    // A/Q/q_m1 transfer network
    always_comb begin
        a_t   = a_q;
        q_t   = q_q;
        qm1_t = qm1_q;

        // c4 and c5 together are illegal: hold the shift registers.
        if (!(c4 && c5)) begin
            if (c5) begin
                a_t = {a_t[W-2:0], q_t[W-1]};
                q_t = {q_t[W-2:0], 1'b0};
            end
            if (c2) begin
                a_t = a_t + m_opnd + {{(W-1){1'b0}}, c3};
            end
            if (c4) begin
                qm1_t = q_t[0];
                q_t   = {a_t[0], q_t[W-1:1]};
                a_t   = {a_t[W-1], a_t[W-1:1]};
            end
            if (c6) begin
                q_t[0] = 1'b1;
            end
        end

        a_d   = a_t;
        q_d   = q_t;
        qm1_d = qm1_t;
        if (c1) begin
            a_d   = '0;
            q_d   = inbus;
            qm1_d = 1'b0;
        end
    end

    // M load, counter and sequence flag
    always_comb begin
        m_d   = m_q;
        cnt_d = cnt_q;
        seq_d = seq_q;

        if (c0)
            m_d = inbus;

        // Reload wins over decrement; decrement at zero simply wraps.
        if (c9)
            cnt_d = CNT_W'(W - 1);
        else if (c10)
            cnt_d = cnt_q - 1'b1;

        // A new M load starts a fresh operation.
        if (c0)
            seq_d = 1'b0;
        else if (c2 || c4 || c5)
            seq_d = 1'b1;
    end

    // State registers with synchronous reset overriding all controls
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            q_q   <= '0;
            a_q   <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
            seq_q <= 1'b0;
        end else begin
            m_q   <= m_d;
            q_q   <= q_d;
            a_q   <= a_d;
            qm1_q <= qm1_d;
            cnt_q <= cnt_d;
            seq_q <= seq_d;
        end
    end

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when the DUT output
// is sampled (after the edge for registered status, mid-cycle for outbus).
module tb_alu_datapath;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    localparam logic [10:0] C0  = 11'h001;
    localparam logic [10:0] C1  = 11'h002;
    localparam logic [10:0] C2  = 11'h004;
    localparam logic [10:0] C3  = 11'h008;
    localparam logic [10:0] C4  = 11'h010;
    localparam logic [10:0] C5  = 11'h020;
    localparam logic [10:0] C6  = 11'h040;
    localparam logic [10:0] C7  = 11'h080;
    localparam logic [10:0] C8  = 11'h100;
    localparam logic [10:0] C9  = 11'h200;
    localparam logic [10:0] C10 = 11'h400;

`ifdef ALU_DP_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] inbus;
    logic [10:0]  ctl;
    logic [W-1:0] outbus;
    logic         q0, q_m1, a_sign, cnt_zero, ovf;

    always #5 clk = ~clk;

    alu_datapath #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .inbus    (inbus),
        .c0       (ctl[0]),
        .c1       (ctl[1]),
        .c2       (ctl[2]),
        .c3       (ctl[3]),
        .c4       (ctl[4]),
        .c5       (ctl[5]),
        .c6       (ctl[6]),
        .c7       (ctl[7]),
        .c8       (ctl[8]),
        .c9       (ctl[9]),
        .c10      (ctl[10]),
        .outbus   (outbus),
        .q0       (q0),
        .q_m1     (q_m1),
        .a_sign   (a_sign),
        .cnt_zero (cnt_zero),
        .ovf      (ovf)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] exp;
    } sb_t;

    sb_t sb[$];
    int  tests = 0;
    int  fails = 0;

    task automatic sb_push(input string tag, input logic [W-1:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [W-1:0] obs);
        sb_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: got %h expected an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                fails++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Apply controls for one full clock; returns just after the edge.
    task automatic cyc(input logic [10:0] c, input logic [W-1:0] d);
        @(negedge clk);
        ctl   = c;
        inbus = d;
        @(posedge clk);
        #1;
    endtask

    // Apply controls mid-cycle to look at the combinational outbus.
    task automatic peek(input logic [10:0] c);
        @(negedge clk);
        ctl   = c;
        inbus = '0;
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        ctl   = '0;
        inbus = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        sb_push("rst_outbus",   8'h00); sb_check(outbus);
        sb_push("rst_q0",       8'h00); sb_check({7'b0, q0});
        sb_push("rst_qm1",      8'h00); sb_check({7'b0, q_m1});
        sb_push("rst_asign",    8'h00); sb_check({7'b0, a_sign});
        sb_push("rst_cntzero",  8'h01); sb_check({7'b0, cnt_zero});
        sb_push("rst_ovf",      8'h00); sb_check({7'b0, ovf});

        // Add 5 + 3
        cyc(C0, 8'h05);
        cyc(C1, 8'h03);
        peek(C7);        sb_push("add_carry", 8'h00); sb_check(outbus);
        peek(C8);        sb_push("add_sum",   8'h08); sb_check(outbus);
        sb_push("add_ovf", 8'h00); sb_check({7'b0, ovf});
        peek('0);        sb_push("idle_bus",  8'h00); sb_check(outbus);

        // Subtract 3 - 5
        cyc(C0, 8'h03);
        cyc(C1, 8'h05);
        peek(C7 | C3);   sb_push("sub_borrow", 8'h01); sb_check(outbus);
        peek(C8 | C3);   sb_push("sub_diff",   8'hFE); sb_check(outbus);
        sb_push("sub_ovf", 8'h00); sb_check({7'b0, ovf});

        // Booth step: A = 0 - 3, then arithmetic shift right
        cyc(C0, 8'h03);
        cyc(C1, 8'h01);
        cyc(C2 | C3 | C4, 8'h00);
        sb_push("booth_asign", 8'h01); sb_check({7'b0, a_sign});
        sb_push("booth_qm1",   8'h01); sb_check({7'b0, q_m1});
        sb_push("booth_q0",    8'h00); sb_check({7'b0, q0});
        sb_push("booth_ovf_gated", 8'h00); sb_check({7'b0, ovf});
        peek(C7);        sb_push("booth_A", 8'hFE); sb_check(outbus);
        peek(C8);        sb_push("booth_Q", 8'h80); sb_check(outbus);

        // Division step: shift left, subtract M, force Q[0]
        cyc(C0, 8'h03);
        cyc(C1, 8'h81);
        cyc(C5 | C2 | C3 | C6, 8'h00);
        peek(C7);        sb_push("div_A", 8'hFE); sb_check(outbus);
        peek(C8);        sb_push("div_Q", 8'h03); sb_check(outbus);
        // Illegal c4+c5 must hold A and Q
        cyc(C4 | C5, 8'h00);
        peek(C7);        sb_push("illegal_A", 8'hFE); sb_check(outbus);
        peek(C8);        sb_push("illegal_Q", 8'h03); sb_check(outbus);
        peek(C7 | C8);   sb_push("c7_wins",   8'hFE); sb_check(outbus);

        // Counter: load W-1, count to zero
        cyc(C9, 8'h00);
        sb_push("cnt_load", 8'h00); sb_check({7'b0, cnt_zero});
        for (int i = 1; i <= 7; i++) begin
            cyc(C10, 8'h00);
            sb_push($sformatf("cnt_dec%0d", i), (i == 7) ? 8'h01 : 8'h00);
            sb_check({7'b0, cnt_zero});
        end
        // Reload beats decrement: seven more decrements to reach zero
        cyc(C9 | C10, 8'h00);
        sb_push("cnt_c9_wins", 8'h00); sb_check({7'b0, cnt_zero});
        for (int i = 1; i <= 7; i++) begin
            cyc(C10, 8'h00);
            sb_push($sformatf("cnt_redec%0d", i), (i == 7) ? 8'h01 : 8'h00);
            sb_check({7'b0, cnt_zero});
        end

        // Overflow 0x7F + 0x01
        cyc(C0, 8'h7F);
        cyc(C1, 8'h01);
        peek(C8);        sb_push("ovf_sum", 8'h80); sb_check(outbus);
        sb_push("ovf_flag", {7'b0, OVF_ON}); sb_check({7'b0, ovf});

        // c0+c1 together load M and Q with the same value
        cyc(C0 | C1, 8'h44);
        peek(C8);        sb_push("c0c1_sum",   8'h88); sb_check(outbus);
        peek(C7);        sb_push("c0c1_carry", 8'h00); sb_check(outbus);
        sb_push("c0c1_ovf", {7'b0, OVF_ON}); sb_check({7'b0, ovf});

        // Reset mid-operation
        cyc(C0, 8'h05);
        cyc(C1, 8'h03);
        cyc(C9, 8'h00);
        @(negedge clk);
        rst   = 1'b1;
        ctl   = C2 | C6;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        ctl = C8;
        #1;
        sb_push("midrst_outbus",  8'h00); sb_check(outbus);
        sb_push("midrst_cntzero", 8'h01); sb_check({7'b0, cnt_zero});
        sb_push("midrst_q0",      8'h00); sb_check({7'b0, q0});

        @(negedge clk);
        ctl = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
